sf_camera_sequencer: RTL and testbench
======================================

# sf_camera_sequencer

Sequences the SparkFun camera bring-up and per-frame capture. It drives the sensor reset, waits for the 20 MHz camera clock generator to lock and for the sensor to start up, then enables the pixel reader and DMA for each frame. It also gates the flash and reports completed frames. It sits between the wishbone control register and the reader/DMA cores.

## Interface
- RESET_CYCLES, 1000: cycles `o_cam_rst` is held asserted.
- STARTUP_CYCLES, 4000: cycles to wait after reset release before the first frame.
- FLASH_CYCLES, 256: maximum `o_flash` high cycles per frame.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- i_control  in  32  control register bits:
  - [0] enable
  - [1] auto_flash
  - [2] single_shot
  - [3] cam_reset_req
- i_clk_locked  in  1  camera clock generator locked.
- i_dma_ready  in  1  DMA has a free buffer.
- i_frame_start  in  1  one-cycle pulse from the reader at frame start (vsync).
- i_frame_done  in  1  one-cycle pulse when the frame is fully written.
- i_flash_strobe  in  1  sensor flash strobe; already synchronized to `clk`.
- o_cam_rst  out  1  sensor reset, 1 = in reset.
- o_flash  out  1  flash LED drive.
- o_status  out  1  1 while the camera is streaming.
- o_enable_reader  out  1  pixel reader enable.
- o_enable_dma  out  1  DMA enable.
- o_captured  out  1  one-cycle frame-captured pulse.
- o_frame_count  out  16  completed frames.
- o_state  out  3  current state, readable in the status register.

## Operation
- States:
  - IDLE=0
  - RESET=1
  - STARTUP=2
  - WAIT_BUF=3
  - ARMED=4
  - CAPTURE=5
  - STOPPED=6
- IDLE: all enables are low. Go to RESET when enable=1 and i_clk_locked=1.
- RESET: o_cam_rst=1. Go to STARTUP after RESET_CYCLES.
- STARTUP: o_cam_rst=0. Go to WAIT_BUF after STARTUP_CYCLES.
- WAIT_BUF: on i_dma_ready=1, go to ARMED.
- ARMED: o_enable_dma=1 and o_enable_reader=1. On i_frame_start, go to CAPTURE.
- CAPTURE: enables stay high. On i_frame_done:
  - pulse o_captured and increment o_frame_count, which wraps 0xFFFF→0;
  - then go to STOPPED if single_shot=1, else to WAIT_BUF. No sensor reset is repeated.
- STOPPED: enables are low. Go to IDLE when enable=0.
- Priority (highest first), evaluated every cycle in any non-IDLE state:
  1. enable=0 or i_clk_locked=0 → IDLE. An in-flight frame is aborted: no o_captured, no count.
  2. Rising edge of cam_reset_req → RESET. The counter is reloaded and enables drop.
  3. The normal transitions above.
- Simultaneous i_frame_start and i_frame_done in ARMED: start wins and done is ignored.
- i_frame_start while in CAPTURE: stay in CAPTURE and restart the flash budget.
- o_status = 1 in ARMED and CAPTURE only.
- Flash: o_flash = auto_flash & i_flash_strobe & (state==CAPTURE) & (flash counter < FLASH_CYCLES).
  - The flash counter clears on each i_frame_start accepted.
  - It counts cycles with o_flash high and saturates at FLASH_CYCLES.

## Timing
- Reset values: o_cam_rst=0, o_flash=0, o_status=0, enables=0, o_captured=0, o_frame_count=0, o_state=IDLE.
- All outputs are registered and reflect the new state the cycle after the transition condition is sampled.
- o_cam_rst is high for exactly RESET_CYCLES consecutive cycles, including when RESET is re-entered.
- The STARTUP dwell is exactly STARTUP_CYCLES cycles.
- Timer width is $clog2(max(RESET_CYCLES,STARTUP_CYCLES)+1). The timer is reloaded on every state entry.
- o_captured is high one cycle after i_frame_done is sampled, coincident with the o_frame_count update.
- Async rst mid-frame forces all outputs to reset values immediately.

## Structure
- Package sf_camera_pkg holds:
  - the state enum encodings;
  - the i_control bit indices (CTRL_ENABLE, CTRL_AUTO_FLASH, CTRL_SINGLE_SHOT, CTRL_CAM_RESET).
- Sub-module sf_camera_timer: loadable down-counter with a `done` output, shared by RESET and STARTUP.
- cam_reset_req edge detection is a single register inside the sequencer.

## Test plan
- RESET_CYCLES=10, STARTUP_CYCLES=20; enable=1, locked=1, dma_ready=1 → o_cam_rst high exactly 10 cycles; o_enable_reader rises 31 cycles after enable is sampled (10 RESET + 20 STARTUP + 1 WAIT_BUF).
- Three start/done frame pairs in continuous mode → three o_captured pulses; o_frame_count=3; state returns to ARMED each time with no further o_cam_rst.
- single_shot=1, one frame → STOPPED, enables low, count=1. Further frame pulses are ignored. enable=0 → IDLE.
- Drop i_clk_locked mid-CAPTURE → IDLE next cycle, no o_captured, count unchanged.
- auto_flash=1, FLASH_CYCLES=4, strobe held high 10 cycles in CAPTURE → o_flash high 4 cycles. Strobe in ARMED → o_flash stays 0.
- Preload count 0xFFFF via 65535 frames (or force) plus one frame → o_frame_count=0. Same-cycle start+done in ARMED → CAPTURE with no capture pulse.

Source files
------------

// File: rtl/sf_camera_pkg.sv
// sf_camera_pkg
//   Shared definitions for the camera sequencer:
//   - cam_state_t : sequencer state encodings (also exported on o_state)
//   - CTRL_*      : bit positions inside the 32-bit control register
//   - max_int     : helper used to size the shared dwell timer
package sf_camera_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RESET    = 3'd1,
      ST_STARTUP  = 3'd2,
      ST_WAIT_BUF = 3'd3,
      ST_ARMED    = 3'd4,
      ST_CAPTURE  = 3'd5,
      ST_STOPPED  = 3'd6
   } cam_state_t;

   localparam int CTRL_ENABLE      = 0;
   localparam int CTRL_AUTO_FLASH  = 1;
   localparam int CTRL_SINGLE_SHOT = 2;
   localparam int CTRL_CAM_RESET   = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sf_camera_timer.sv
// sf_camera_timer
//   Loadable down-counter shared by the RESET and STARTUP dwells.
//   Loading N-1 on state entry makes `done` assert on the N-th cycle spent
//   in that state, so the dwell is exactly N cycles.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load load_value this cycle (takes priority over counting)
//   load_value  value loaded into the counter
//   done        counter has reached zero
module sf_camera_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/sf_camera_sequencer.sv
// sf_camera_sequencer
//   Camera bring-up and per-frame capture sequencer. Holds the sensor in
//   reset, waits for it to start up, then arms the pixel reader and DMA for
//   each frame, gates the flash and counts completed frames.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_control        control register: enable, auto_flash, single_shot,
//                    cam_reset_req (bit indices in sf_camera_pkg)
//   i_clk_locked     camera clock generator locked
//   i_dma_ready      DMA has a free buffer
//   i_frame_start    one-cycle frame start pulse from the reader
//   i_frame_done     one-cycle frame written pulse
//   i_flash_strobe   sensor flash strobe (already in clk domain)
//   o_cam_rst        sensor reset, 1 = in reset
//   o_flash          flash LED drive
//   o_status         streaming (ARMED or CAPTURE)
//   o_enable_reader  pixel reader enable
//   o_enable_dma     DMA enable
//   o_captured       one-cycle frame captured pulse
//   o_frame_count    completed frames, wraps
//   o_state          current state (cam_state_t encoding)
// Handshake: i_frame_start / i_frame_done are single-cycle qualifiers,
// sampled only in the states that accept them; pulses arriving elsewhere are
// dropped. i_dma_ready is a level sampled in WAIT_BUF.
// All outputs are registered from the next-state decode, so they change on
// the same edge that moves the state.
module sf_camera_sequencer
   import sf_camera_pkg::*;
#(
   parameter int RESET_CYCLES   = 1000,
   parameter int STARTUP_CYCLES = 4000,
   parameter int FLASH_CYCLES   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_control,
   input  logic        i_clk_locked,
   input  logic        i_dma_ready,
   input  logic        i_frame_start,
   input  logic        i_frame_done,
   input  logic        i_flash_strobe,
   output logic        o_cam_rst,
   output logic        o_flash,
   output logic        o_status,
   output logic        o_enable_reader,
   output logic        o_enable_dma,
   output logic        o_captured,
   output logic [15:0] o_frame_count,
   output logic [2:0]  o_state
);

   localparam int TW = $clog2(max_int(RESET_CYCLES, STARTUP_CYCLES) + 1);
   localparam int FW = $clog2(FLASH_CYCLES + 1);

   cam_state_t    state, state_next;
   logic          req_q;
   logic          req_rise;
   logic          timer_load;
   logic [TW-1:0] timer_value;
   logic          timer_done;
   logic          start_acc;
   logic          capture;
   logic [15:0]   frame_count;
   logic [FW-1:0] flash_cnt, flash_base, flash_cnt_next;
   logic          flash_fire;
   logic          streaming_next;

   logic enable, auto_flash, single_shot;
   logic unused_ctrl;

   assign enable      = i_control[CTRL_ENABLE];
   assign auto_flash  = i_control[CTRL_AUTO_FLASH];
   assign single_shot = i_control[CTRL_SINGLE_SHOT];
   assign unused_ctrl = ^i_control[31:4];

   // Only a rising edge of cam_reset_req restarts the sensor; holding it high
   // does not keep the sequencer in RESET.
   assign req_rise = i_control[CTRL_CAM_RESET] & ~req_q;

   sf_camera_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   // Next state: abort conditions override a cam reset request, which
   // overrides the normal flow.
   always_comb begin
      state_next  = state;
      timer_load  = 1'b0;
      timer_value = '0;
      start_acc   = 1'b0;
      capture     = 1'b0;

      if (state == ST_IDLE) begin
         if (enable && i_clk_locked) begin
            state_next  = ST_RESET;
            timer_load  = 1'b1;
            timer_value = TW'(RESET_CYCLES - 1);
         end
      end else if (!enable || !i_clk_locked) begin
         state_next = ST_IDLE;
      end else if (req_rise) begin
         state_next  = ST_RESET;
         timer_load  = 1'b1;
         timer_value = TW'(RESET_CYCLES - 1);
      end else begin
         case (state)
            ST_RESET: begin
               if (timer_done) begin
                  state_next  = ST_STARTUP;
                  timer_load  = 1'b1;
                  timer_value = TW'(STARTUP_CYCLES - 1);
               end
            end
            ST_STARTUP: begin
               if (timer_done) state_next = ST_WAIT_BUF;
            end
            ST_WAIT_BUF: begin
               if (i_dma_ready) state_next = ST_ARMED;
            end
            ST_ARMED: begin
               // A done arriving with the start belongs to no captured frame.
               if (i_frame_start) begin
                  state_next = ST_CAPTURE;
                  start_acc  = 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (i_frame_start) begin
                  start_acc = 1'b1;
               end else if (i_frame_done) begin
                  capture    = 1'b1;
                  state_next = single_shot ? ST_STOPPED : ST_WAIT_BUF;
               end
            end
            default: state_next = state;
         endcase
      end
   end

   // Flash budget: restarts on every accepted frame start and stops the
   // flash once FLASH_CYCLES high cycles have been spent.
   always_comb begin
      flash_base     = start_acc ? '0 : flash_cnt;
      flash_fire     = auto_flash && i_flash_strobe && (state_next == ST_CAPTURE)
                       && (flash_base < FW'(FLASH_CYCLES));
      flash_cnt_next = flash_fire ? flash_base + 1'b1 : flash_base;
   end

   assign streaming_next = (state_next == ST_ARMED) || (state_next == ST_CAPTURE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         req_q           <= 1'b0;
         o_cam_rst       <= 1'b0;
         o_flash         <= 1'b0;
         o_status        <= 1'b0;
         o_enable_reader <= 1'b0;
         o_enable_dma    <= 1'b0;
         o_captured      <= 1'b0;
         frame_count     <= '0;
         flash_cnt       <= '0;
      end else begin
         state           <= state_next;
         req_q           <= i_control[CTRL_CAM_RESET];
         o_cam_rst       <= (state_next == ST_RESET);
         o_flash         <= flash_fire;
         o_status        <= streaming_next;
         o_enable_reader <= streaming_next;
         o_enable_dma    <= streaming_next;
         o_captured      <= capture;
         flash_cnt       <= flash_cnt_next;
         if (capture) frame_count <= frame_count + 16'd1;
      end
   end

   assign o_frame_count = frame_count;
   assign o_state       = state;

endmodule

// File: tb/tb_sf_camera_sequencer.sv
// tb_sf_camera_sequencer
//   Scenario bench for sf_camera_sequencer with short dwell parameters.
//   A reference model (expected frame count and expected-capture queue) is
//   kept here; a scoreboard process pops the queue on every o_captured.
module tb_sf_camera_sequencer;

   localparam int RC = 10;
   localparam int SC = 20;
   localparam int FC = 4;
   localparam int BRINGUP_LAT = RC + SC + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en_b, flash_b, single_b, req_b;
   logic [31:0] i_control;
   logic        i_clk_locked, i_dma_ready, i_frame_start, i_frame_done, i_flash_strobe;
   logic        o_cam_rst, o_flash, o_status, o_enable_reader, o_enable_dma, o_captured;
   logic [15:0] o_frame_count;
   logic [2:0]  o_state;

   assign i_control = {28'd0, req_b, single_b, flash_b, en_b};

   sf_camera_sequencer #(
      .RESET_CYCLES   (RC),
      .STARTUP_CYCLES (SC),
      .FLASH_CYCLES   (FC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_control       (i_control),
      .i_clk_locked    (i_clk_locked),
      .i_dma_ready     (i_dma_ready),
      .i_frame_start   (i_frame_start),
      .i_frame_done    (i_frame_done),
      .i_flash_strobe  (i_flash_strobe),
      .o_cam_rst       (o_cam_rst),
      .o_flash         (o_flash),
      .o_status        (o_status),
      .o_enable_reader (o_enable_reader),
      .o_enable_dma    (o_enable_dma),
      .o_captured      (o_captured),
      .o_frame_count   (o_frame_count),
      .o_state         (o_state)
   );

   // ---------------- model / scoreboard ----------------
   int          errors = 0;
   int          checks = 0;
   int          exp_count = 0;
   int          cam_rst_cycles = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   always @(posedge clk) begin
      #1;
      if (o_cam_rst === 1'b1) cam_rst_cycles++;
      if (o_captured === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_capture: o_captured=1 count=%0d, required no pulse", o_frame_count);
         end else begin
            mon_exp = exp_q.pop_front();
            if (o_frame_count !== mon_exp) begin
               errors++;
               $display("FAIL capture_count: o_frame_count=%0d, required %0d", o_frame_count, mon_exp);
            end
         end
      end
   end

   // Model: one completed frame adds one to the 16-bit count.
   task automatic expect_frame();
      exp_count = (exp_count + 1) % 65536;
      exp_q.push_back(16'(exp_count));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
   endtask

   task automatic pulse_done();
      i_frame_done = 1'b1;
      tick();
      i_frame_done = 1'b0;
   endtask

   // Ticks until the reader is enabled; returns edges taken (bounded).
   task automatic wait_reader(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (o_enable_reader !== 1'b1 && n < 200);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      en_b = 0; flash_b = 0; single_b = 0; req_b = 0;
      i_clk_locked = 0; i_dma_ready = 0; i_frame_start = 0; i_frame_done = 0; i_flash_strobe = 0;
      repeat (3) tick();
      checks++;
      if ({o_cam_rst, o_flash, o_status, o_enable_reader, o_enable_dma, o_captured} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 000000",
                  {o_cam_rst, o_flash, o_status, o_enable_reader, o_enable_dma, o_captured});
      end
      checks++;
      if (o_frame_count !== 16'd0 || o_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_count_state: count=%0d state=%0d, required 0/0", o_frame_count, o_state);
      end
      @(negedge clk);
      rst = 1'b0;
      i_clk_locked = 1'b1;
      repeat (3) tick();
      checks++;
      if (o_state !== 3'd0) begin
         errors++;
         $display("FAIL idle_without_enable: state=%0d, required 0", o_state);
      end
   endtask

   task automatic test_bringup();
      int n;
      int rst0;
      i_dma_ready = 1'b1;
      en_b = 1'b1;
      rst0 = cam_rst_cycles;
      wait_reader(n);
      checks++;
      if (n - 1 != BRINGUP_LAT) begin
         errors++;
         $display("FAIL bringup_latency: %0d cycles, required %0d", n - 1, BRINGUP_LAT);
      end
      checks++;
      if (cam_rst_cycles - rst0 != RC) begin
         errors++;
         $display("FAIL cam_rst_width: %0d cycles, required %0d", cam_rst_cycles - rst0, RC);
      end
      checks++;
      if (o_state !== 3'd4 || o_status !== 1'b1 || o_enable_dma !== 1'b1) begin
         errors++;
         $display("FAIL armed_outputs: state=%0d status=%b dma=%b, required 4/1/1", o_state, o_status, o_enable_dma);
      end
   endtask

   task automatic test_continuous();
      int rst0;
      rst0 = cam_rst_cycles;
      for (int f = 0; f < 3; f++) begin
         repeat ($urandom_range(0, 3)) tick();
         pulse_start();
         checks++;
         if (o_state !== 3'd5 || o_enable_reader !== 1'b1) begin
            errors++;
            $display("FAIL capture_entry: state=%0d reader=%b, required 5/1", o_state, o_enable_reader);
         end
         repeat ($urandom_range(0, 4)) tick();
         i_dma_ready = 1'b0;
         expect_frame();
         pulse_done();
         checks++;
         if (o_captured !== 1'b1 || o_state !== 3'd3) begin
            errors++;
            $display("FAIL frame_complete: captured=%b state=%0d, required 1/3", o_captured, o_state);
         end
         repeat ($urandom_range(1, 4)) tick();
         checks++;
         if (o_state !== 3'd3 || o_enable_reader !== 1'b0) begin
            errors++;
            $display("FAIL wait_buf_hold: state=%0d reader=%b, required 3/0", o_state, o_enable_reader);
         end
         i_dma_ready = 1'b1;
         tick();
         checks++;
         if (o_state !== 3'd4) begin
            errors++;
            $display("FAIL rearm: state=%0d, required 4", o_state);
         end
      end
      checks++;
      if (o_frame_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL continuous_count: count=%0d, required %0d", o_frame_count, exp_count);
      end
      checks++;
      if (cam_rst_cycles != rst0) begin
         errors++;
         $display("FAIL no_repeat_reset: %0d cam_rst cycles, required 0", cam_rst_cycles - rst0);
      end
   endtask

   task automatic test_single_shot();
      single_b = 1'b1;
      pulse_start();
      expect_frame();
      pulse_done();
      checks++;
      if (o_state !== 3'd6 || o_enable_reader !== 1'b0 || o_enable_dma !== 1'b0) begin
         errors++;
         $display("FAIL stopped_entry: state=%0d reader=%b dma=%b, required 6/0/0", o_state, o_enable_reader, o_enable_dma);
      end
      pulse_start();
      tick();
      pulse_done();
      tick();
      checks++;
      if (o_state !== 3'd6 || o_frame_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL stopped_ignores: state=%0d count=%0d, required 6/%0d", o_state, o_frame_count, exp_count);
      end
      en_b = 1'b0;
      tick();
      checks++;
      if (o_state !== 3'd0) begin
         errors++;
         $display("FAIL stopped_to_idle: state=%0d, required 0", o_state);
      end
      single_b = 1'b0;
   endtask

   task automatic test_lock_drop();
      int n;
      en_b = 1'b1;
      wait_reader(n);
      checks++;
      if (n - 1 != BRINGUP_LAT) begin
         errors++;
         $display("FAIL rebringup_latency: %0d cycles, required %0d", n - 1, BRINGUP_LAT);
      end
      pulse_start();
      repeat ($urandom_range(0, 3)) tick();
      i_clk_locked = 1'b0;
      i_frame_done = 1'b1;
      tick();
      i_frame_done = 1'b0;
      checks++;
      if (o_state !== 3'd0 || o_captured !== 1'b0 || o_frame_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL lock_abort: state=%0d captured=%b count=%0d, required 0/0/%0d",
                  o_state, o_captured, o_frame_count, exp_count);
      end
      i_clk_locked = 1'b1;
   endtask

   task automatic test_cam_reset();
      int n;
      int hi;
      wait_reader(n);
      req_b = 1'b1;
      tick();
      checks++;
      if (o_state !== 3'd1 || o_cam_rst !== 1'b1 || o_enable_reader !== 1'b0) begin
         errors++;
         $display("FAIL cam_reset_entry: state=%0d cam_rst=%b reader=%b, required 1/1/0", o_state, o_cam_rst, o_enable_reader);
      end
      req_b = 1'b0;
      repeat (3) tick();
      req_b = 1'b1;
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_cam_rst !== 1'b1) break;
         hi++;
      end
      checks++;
      if (hi != RC) begin
         errors++;
         $display("FAIL reset_reentry_width: %0d cycles, required %0d", hi, RC);
      end
      wait_reader(n);
      checks++;
      if (o_state !== 3'd4) begin
         errors++;
         $display("FAIL cam_reset_rearm: state=%0d, required 4", o_state);
      end
      req_b = 1'b0;
   endtask

   task automatic test_flash();
      int fl;
      int len;
      flash_b = 1'b1;
      i_flash_strobe = 1'b1;
      fl = 0;
      repeat (5) begin tick(); if (o_flash === 1'b1) fl++; end
      i_flash_strobe = 1'b0;
      checks++;
      if (fl != 0) begin
         errors++;
         $display("FAIL flash_in_armed: %0d cycles, required 0", fl);
      end
      pulse_start();
      len = 10;
      fl = 0;
      i_flash_strobe = 1'b1;
      repeat (len) begin tick(); if (o_flash === 1'b1) fl++; end
      i_flash_strobe = 1'b0;
      tick();
      if (o_flash === 1'b1) fl++;
      checks++;
      if (fl != ((len < FC) ? len : FC)) begin
         errors++;
         $display("FAIL flash_budget: %0d cycles, required %0d", fl, (len < FC) ? len : FC);
      end
      pulse_start();
      len = $urandom_range(2, 7);
      fl = 0;
      i_flash_strobe = 1'b1;
      repeat (len) begin tick(); if (o_flash === 1'b1) fl++; end
      i_flash_strobe = 1'b0;
      checks++;
      if (fl != ((len < FC) ? len : FC) || o_state !== 3'd5) begin
         errors++;
         $display("FAIL flash_restart: %0d cycles state=%0d, required %0d/5", fl, o_state, (len < FC) ? len : FC);
      end
      expect_frame();
      pulse_done();
      tick();
      flash_b = 1'b0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.frame_count = 16'hFFFF;
      #1;
      release dut.frame_count;
      exp_count = 16'hFFFF;
      tick();
      pulse_start();
      expect_frame();
      pulse_done();
      checks++;
      if (o_frame_count !== 16'h0000) begin
         errors++;
         $display("FAIL count_wrap: count=%0d, required 0", o_frame_count);
      end
      tick();
      i_frame_start = 1'b1;
      i_frame_done  = 1'b1;
      tick();
      i_frame_start = 1'b0;
      i_frame_done  = 1'b0;
      checks++;
      if (o_state !== 3'd5 || o_captured !== 1'b0 || o_frame_count !== 16'(exp_count)) begin
         errors++;
         $display("FAIL start_done_same_cycle: state=%0d captured=%b count=%0d, required 5/0/%0d",
                  o_state, o_captured, o_frame_count, exp_count);
      end
      expect_frame();
      pulse_done();
      tick();
   endtask

   task automatic test_async_reset();
      pulse_start();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_cam_rst, o_flash, o_status, o_enable_reader, o_enable_dma, o_captured} !== 6'b0
          || o_frame_count !== 16'd0 || o_state !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: outs=%b count=%0d state=%0d, required 0/0/0",
                  {o_cam_rst, o_flash, o_status, o_enable_reader, o_enable_dma, o_captured}, o_frame_count, o_state);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_captures: %0d pending, required 0", exp_q.size());
      end
      @(negedge clk);
      rst = 1'b0;
      en_b = 1'b0;
      exp_count = 0;
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_bringup();
      test_continuous();
      test_single_shot();
      test_lock_drop();
      test_cam_reset();
      test_flash();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
